// File: rtl/mem_io_responder.sv
// mem_io_responder: responder end of the CPU byte bus. RAM accesses pass
// straight through to an external synchronous RAM. The I/O window at 0x30000
// holds the UART TX/RX FIFOs, a cycle counter and the program-stop latch.
// Read data always appears one cycle after the address.
module mem_io_responder #(
    parameter int TX_DEPTH_LOG = 3,
    parameter int RX_DEPTH_LOG = 3,
    parameter int FULL_MARGIN  = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] mem_a,
    input  logic        mem_wr,
    input  logic [7:0]  mem_dout,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic [16:0] ram_addr,
    output logic        ram_we,
    output logic [7:0]  ram_wdata,
    input  logic [7:0]  ram_rdata,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        program_stop
);
    localparam int TX_DEPTH = 1 << TX_DEPTH_LOG;
    localparam int RX_DEPTH = 1 << RX_DEPTH_LOG;
    localparam logic [TX_DEPTH_LOG:0] TX_FULL_CNT = (TX_DEPTH_LOG+1)'(TX_DEPTH);
    localparam logic [TX_DEPTH_LOG:0] TX_THRESH   = (TX_DEPTH_LOG+1)'(TX_DEPTH - FULL_MARGIN);
    localparam logic [RX_DEPTH_LOG:0] RX_FULL_CNT = (RX_DEPTH_LOG+1)'(RX_DEPTH);

    // Upper address bits are outside the decoded 256KB space.
    logic unused_addr_hi;
    assign unused_addr_hi = ^mem_a[31:18];

    // ---------------- decode ----------------
    logic        io;
    logic [15:0] off;
    logic        tx_wr, stop_wr, rx_rd, cnt_rd;

    assign io      = (mem_a[17:16] == 2'b11);
    assign off     = mem_a[15:0];
    assign tx_wr   = io &  mem_wr & (off == 16'h0000);
    assign stop_wr = io &  mem_wr & (off == 16'h0004);
    assign rx_rd   = io & ~mem_wr & (off == 16'h0000);
    assign cnt_rd  = io & ~mem_wr & (off[15:2] == 14'h0001);

    // RAM side is pure pass-through; only the write enable is gated by decode.
    assign ram_addr  = mem_a[16:0];
    assign ram_wdata = mem_dout;
    assign ram_we    = mem_wr & ~io;

    // ---------------- TX FIFO ----------------
    logic [7:0]              tx_mem [TX_DEPTH];
    logic [TX_DEPTH_LOG-1:0] tx_wp, tx_rp;
    logic [TX_DEPTH_LOG:0]   tx_cnt;
    logic                    tx_full, tx_pop, tx_push;
    logic [7:0]              tx_byte;

    assign tx_full        = (tx_cnt == TX_FULL_CNT);
    assign tx_valid       = (tx_cnt != '0);
    assign tx_data        = tx_mem[tx_rp];
    assign tx_pop         = tx_valid & tx_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign tx_push        = ((tx_wr & (|mem_dout)) | stop_wr) & (~tx_full | tx_pop);
    // The stop marker is a literal zero that bypasses the zero filter.
    assign tx_byte        = stop_wr ? 8'h00 : mem_dout;
    assign io_buffer_full = (tx_cnt >= TX_THRESH);

    // TX storage: no reset needed, validity is tracked by the count.
    always_ff @(posedge clk_in) begin
        if (tx_push) tx_mem[tx_wp] <= tx_byte;
    end

    // TX pointers and occupancy.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            tx_wp  <= '0;
            tx_rp  <= '0;
            tx_cnt <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + TX_DEPTH_LOG'(1);
            if (tx_pop)  tx_rp <= tx_rp + TX_DEPTH_LOG'(1);
            case ({tx_push, tx_pop})
                2'b10:   tx_cnt <= tx_cnt + (TX_DEPTH_LOG+1)'(1);
                2'b01:   tx_cnt <= tx_cnt - (TX_DEPTH_LOG+1)'(1);
                default: tx_cnt <= tx_cnt;
            endcase
        end
    end

    // ---------------- RX FIFO ----------------
    logic [7:0]              rx_mem [RX_DEPTH];
    logic [RX_DEPTH_LOG-1:0] rx_wp, rx_rp;
    logic [RX_DEPTH_LOG:0]   rx_cnt;
    logic                    rx_push, rx_pop;

    assign rx_ready = (rx_cnt != RX_FULL_CNT);
    assign rx_push  = rx_valid & rx_ready;
    assign rx_pop   = rx_rd & (rx_cnt != '0);

    // RX storage.
    always_ff @(posedge clk_in) begin
        if (rx_push) rx_mem[rx_wp] <= rx_data;
    end

    // RX pointers and occupancy.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rx_wp  <= '0;
            rx_rp  <= '0;
            rx_cnt <= '0;
        end else begin
            if (rx_push) rx_wp <= rx_wp + RX_DEPTH_LOG'(1);
            if (rx_pop)  rx_rp <= rx_rp + RX_DEPTH_LOG'(1);
            case ({rx_push, rx_pop})
                2'b10:   rx_cnt <= rx_cnt + (RX_DEPTH_LOG+1)'(1);
                2'b01:   rx_cnt <= rx_cnt - (RX_DEPTH_LOG+1)'(1);
                default: rx_cnt <= rx_cnt;
            endcase
        end
    end

    // ---------------- counter, read mux, stop ----------------
    logic [31:0] cycle_cnt, snap;
    logic [7:0]  io_rdata_d, io_rdata_q;
    logic        sel_ram_q;

    // I/O read data for this cycle's address; zero for anything unmapped.
    always_comb begin
        io_rdata_d = 8'h00;
        if (rx_pop) begin
            io_rdata_d = rx_mem[rx_rp];
        end else if (cnt_rd) begin
            case (off[1:0])
                2'd0:    io_rdata_d = cycle_cnt[7:0];
                2'd1:    io_rdata_d = snap[15:8];
                2'd2:    io_rdata_d = snap[23:16];
                default: io_rdata_d = snap[31:24];
            endcase
        end
    end

    // Response registers, free-running counter, coherent snapshot, stop latch.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            sel_ram_q    <= 1'b0;
            io_rdata_q   <= 8'h00;
            cycle_cnt    <= '0;
            snap         <= '0;
            program_stop <= 1'b0;
        end else begin
            sel_ram_q  <= ~io & ~mem_wr;
            io_rdata_q <= io_rdata_d;
            cycle_cnt  <= cycle_cnt + 32'd1;
            if (cnt_rd && off[1:0] == 2'd0) snap <= cycle_cnt;
            if (stop_wr) program_stop <= 1'b1;
        end
    end

    assign mem_din = sel_ram_q ? ram_rdata : io_rdata_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Bench for mem_io_responder: directed bus vectors with a scoreboard for
// read data and for the TX byte stream, plus a 128KB synchronous RAM model.
module tb_mem_io_responder;
    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic [16:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        program_stop;

    localparam logic [31:0] IDLE_A = 32'h0003_0010;
    localparam logic [31:0] IO_TX  = 32'h0003_0000;
    localparam logic [31:0] IO_CNT = 32'h0003_0004;

    typedef struct {
        int         tag;
        logic [7:0] val;
        string      nm;
    } ent_t;

    ent_t        mq[$];
    logic [7:0]  tx_exp[$];
    ent_t        mon_e;
    int          n_assert = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [31:0] tb_cnt;
    logic [7:0]  ram [0:131071];

    mem_io_responder dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .mem_a(mem_a), .mem_wr(mem_wr), .mem_dout(mem_dout), .mem_din(mem_din),
        .io_buffer_full(io_buffer_full),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .program_stop(program_stop)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    // Cycles elapsed since reset release: the value the DUT counter should show.
    always @(posedge clk_in or negedge rst_in)
        if (!rst_in) tb_cnt <= 32'd0;
        else         tb_cnt <= tb_cnt + 32'd1;

    // External synchronous RAM, one cycle read latency.
    always @(posedge clk_in) begin
        if (ram_we) ram[ram_addr] <= ram_wdata;
        ram_rdata <= ram[ram_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: read data for the previous cycle's address, and TX handshakes.
    always @(negedge clk_in) begin
        #3;
        if (mq.size() > 0 && mq[0].tag == cyc - 1) begin
            mon_e = mq.pop_front();
            chk(mon_e.nm, {24'h0, mem_din}, {24'h0, mon_e.val});
        end
        if (rst_in && tx_valid && tx_ready) begin
            if (tx_exp.size() == 0) begin
                n_assert++;
                n_fail++;
                $display("FAIL tx_extra: got byte %0h, expected no byte", tx_data);
            end else begin
                chk("tx_data", {24'h0, tx_data}, {24'h0, tx_exp.pop_front()});
            end
        end
    end

    // One bus cycle; optionally queue the expected read data for next cycle.
    task automatic step(input string nm, input logic [31:0] a, input logic wr,
                        input logic [7:0] d, input logic has, input logic [7:0] exp,
                        input logic rv, input logic [7:0] rd);
        ent_t e;
        @(negedge clk_in);
        mem_a = a; mem_wr = wr; mem_dout = d; rx_valid = rv; rx_data = rd;
        if (has) begin
            e.tag = cyc; e.val = exp; e.nm = nm;
            mq.push_back(e);
        end
        #1;
    endtask

    task automatic bus(input string nm, input logic [31:0] a, input logic wr,
                       input logic [7:0] d, input logic [7:0] exp);
        step(nm, a, wr, d, 1'b1, exp, 1'b0, 8'h00);
    endtask

    task automatic idle();
        step("idle", IDLE_A, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00);
    endtask

    task automatic rxpush(input logic [7:0] b);
        step("rxpush", IDLE_A, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, b);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        int guard;
        mem_a = IDLE_A; mem_wr = 1'b0; mem_dout = 8'h00;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;

        // Reset state
        repeat (2) @(negedge clk_in);
        #1;
        chk("rst_mem_din",  {24'h0, mem_din}, 32'h0);
        chk("rst_ibf",      {31'h0, io_buffer_full}, 32'h0);
        chk("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        chk("rst_rx_ready", {31'h0, rx_ready}, 32'h1);
        chk("rst_stop",     {31'h0, program_stop}, 32'h0);
        @(negedge clk_in);
        rst_in = 1'b1;

        // RAM write then read
        bus("ram_wr_resp", 32'h0000_0123, 1'b1, 8'hA5, 8'h00);
        chk("ram_we_wr",   {31'h0, ram_we}, 32'h1);
        chk("ram_addr",    {15'h0, ram_addr}, 32'h123);
        chk("ram_wdata",   {24'h0, ram_wdata}, 32'hA5);
        bus("ram_rd", 32'h0000_0123, 1'b0, 8'h00, 8'hA5);
        chk("ram_we_rd",   {31'h0, ram_we}, 32'h0);
        idle();

        // TX zero filter with tx_ready held high
        tx_ready = 1'b1;
        bus("tx_wr_resp", IO_TX, 1'b1, 8'h41, 8'h00); tx_exp.push_back(8'h41);
        bus("tx_wr_resp", IO_TX, 1'b1, 8'h00, 8'h00);
        chk("io_ram_we",   {31'h0, ram_we}, 32'h0);
        bus("tx_wr_resp", IO_TX, 1'b1, 8'h42, 8'h00); tx_exp.push_back(8'h42);
        repeat (3) idle();
        chk("tx_idle_valid", {31'h0, tx_valid}, 32'h0);
        chk("tx_q_drained",  tx_exp.size(), 32'h0);

        // Backpressure, threshold and overflow drop
        tx_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            bus("tx_wr_resp", IO_TX, 1'b1, 8'(i), 8'h00);
            tx_exp.push_back(8'(i));
        end
        idle();
        chk("ibf_cnt5", {31'h0, io_buffer_full}, 32'h0);
        bus("tx_wr_resp", IO_TX, 1'b1, 8'h06, 8'h00); tx_exp.push_back(8'h06);
        idle();
        chk("ibf_cnt6", {31'h0, io_buffer_full}, 32'h1);
        bus("tx_wr_resp", IO_TX, 1'b1, 8'h07, 8'h00); tx_exp.push_back(8'h07);
        bus("tx_wr_resp", IO_TX, 1'b1, 8'h08, 8'h00); tx_exp.push_back(8'h08);
        bus("tx_wr_resp", IO_TX, 1'b1, 8'h09, 8'h00);
        idle();
        chk("tx_full_valid", {31'h0, tx_valid}, 32'h1);
        chk("tx_full_head",  {24'h0, tx_data}, 32'h01);
        tx_ready = 1'b1;
        repeat (12) idle();
        chk("tx_drain_valid", {31'h0, tx_valid}, 32'h0);
        chk("tx_drain_ibf",   {31'h0, io_buffer_full}, 32'h0);
        chk("tx_drain_count", tx_exp.size(), 32'h0);

        // Counter snapshot coherence around 0x1FF -> 0x200
        guard = 0;
        while (tb_cnt < 32'h1FE && guard < 2000) begin
            idle();
            guard++;
        end
        v = tb_cnt + 32'd1;
        bus("cnt_b0", IO_CNT,              1'b0, 8'h00, v[7:0]);
        bus("cnt_b1", IO_CNT + 32'd1,      1'b0, 8'h00, v[15:8]);
        bus("cnt_b2", IO_CNT + 32'd2,      1'b0, 8'h00, v[23:16]);
        bus("cnt_b3", IO_CNT + 32'd3,      1'b0, 8'h00, v[31:24]);
        bus("unmapped_rd", 32'h0003_0008, 1'b0, 8'h00, 8'h00);

        // RX FIFO
        rxpush(8'h11);
        rxpush(8'h22);
        bus("rx_rd0", IO_TX, 1'b0, 8'h00, 8'h11);
        bus("rx_rd1", IO_TX, 1'b0, 8'h00, 8'h22);
        bus("rx_rd_empty", IO_TX, 1'b0, 8'h00, 8'h00);
        rxpush(8'h33);
        step("rx_rd_simul", IO_TX, 1'b0, 8'h00, 1'b1, 8'h33, 1'b1, 8'h44);
        bus("rx_rd_after", IO_TX, 1'b0, 8'h00, 8'h44);
        bus("rx_rd_empty2", IO_TX, 1'b0, 8'h00, 8'h00);
        for (int i = 0; i < 8; i++) rxpush(8'h50 + 8'(i));
        idle();
        chk("rx_full_ready", {31'h0, rx_ready}, 32'h0);
        rxpush(8'hEE);
        idle();
        chk("rx_full_ready2", {31'h0, rx_ready}, 32'h0);
        for (int i = 0; i < 8; i++) bus("rx_full_rd", IO_TX, 1'b0, 8'h00, 8'h50 + 8'(i));
        bus("rx_rd_empty3", IO_TX, 1'b0, 8'h00, 8'h00);
        idle();
        chk("rx_ready_again", {31'h0, rx_ready}, 32'h1);

        // Program stop, then reset in the middle of a drain
        tx_ready = 1'b0;
        bus("stop_wr_resp", IO_CNT, 1'b1, 8'h99, 8'h00); tx_exp.push_back(8'h00);
        bus("tx_wr_resp", IO_TX, 1'b1, 8'h61, 8'h00);   tx_exp.push_back(8'h61);
        bus("tx_wr_resp", IO_TX, 1'b1, 8'h62, 8'h00);   tx_exp.push_back(8'h62);
        idle();
        chk("stop_set",     {31'h0, program_stop}, 32'h1);
        chk("stop_tx_head", {24'h0, tx_data}, 32'h00);
        chk("stop_tx_vld",  {31'h0, tx_valid}, 32'h1);
        tx_ready = 1'b1;
        idle();
        @(negedge clk_in);
        rst_in = 1'b0;
        #1;
        chk("mid_rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        chk("mid_rst_stop",     {31'h0, program_stop}, 32'h0);
        chk("mid_rst_mem_din",  {24'h0, mem_din}, 32'h0);
        chk("mid_rst_ibf",      {31'h0, io_buffer_full}, 32'h0);
        tx_exp.delete();
        mq.delete();
        repeat (2) @(negedge clk_in);
        begin
            ent_t e;
            @(negedge clk_in);
            rst_in = 1'b1;
            mem_a = IO_CNT; mem_wr = 1'b0; mem_dout = 8'h00;
            e.tag = cyc; e.val = 8'h00; e.nm = "cnt_after_rst0";
            mq.push_back(e);
            #1;
        end
        bus("cnt_after_rst1", IO_CNT, 1'b0, 8'h00, 8'h01);
        bus("cnt_after_rst2", IO_CNT, 1'b0, 8'h00, 8'h02);
        repeat (3) idle();
        chk("tx_after_rst_valid", {31'h0, tx_valid}, 32'h0);
        chk("read_q_empty",       mq.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
